// File: rtl/regfile_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// requester IDs and the "no grant" code.
package regfile_wb_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_ADDR_WIDTH   = 5;
   localparam int unsigned DEF_NUM_REQ      = 3;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

   localparam int unsigned GNT_W = 2;
   typedef logic [GNT_W-1:0] gnt_id_t;

   localparam gnt_id_t REQ_ALU     = 2'd0;
   localparam gnt_id_t REQ_MULTDIV = 2'd1;
   localparam gnt_id_t REQ_LOADER  = 2'd2;
   localparam gnt_id_t GRANT_NONE  = 2'd3;

   // Width of an age counter that saturates at the given limit.
   function automatic int unsigned age_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/wb_req_slot.sv
// One-entry writeback holding slot with a saturating age counter used by the
// arbiter to promote long-waiting entries.
module wb_req_slot
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                  clock,
   input  logic                  ctrl_reset_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_reg,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_grant,
   output logic                  o_valid,
   output logic                  o_starved,
   output logic [ADDR_WIDTH-1:0] o_reg,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam int unsigned     AGE_W   = age_width(STARVE_LIMIT);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

   logic                  r_valid;
   logic [AGE_W-1:0]      r_age;
   logic [ADDR_WIDTH-1:0] r_reg;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  w_capture;

   // No bypass: a slot only accepts while empty, so capture and grant never collide.
   assign w_capture = i_valid & ~r_valid;

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_valid <= 1'b0;
         r_age   <= '0;
         r_reg   <= '0;
         r_data  <= '0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_age   <= '0;
         r_reg   <= i_reg;
         r_data  <= i_data;
      end else if (r_valid) begin
         if (i_grant) begin
            r_valid <= 1'b0;
         end else if (r_age != AGE_MAX) begin
            r_age <= r_age + AGE_W'(1);
         end
      end
   end

   assign o_ready   = ~r_valid;
   assign o_valid   = r_valid;
   assign o_starved = r_valid && (r_age == AGE_MAX);
   assign o_reg     = r_reg;
   assign o_data    = r_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port, plus a busy-register
// scoreboard used by issue logic to stall on RAW hazards.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                            clock,
   input  logic                            ctrl_reset_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_reg,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic                            claim_valid,
   input  logic [ADDR_WIDTH-1:0]           claim_reg,
   input  logic [ADDR_WIDTH-1:0]           query_regA,
   input  logic [ADDR_WIDTH-1:0]           query_regB,
   output logic                            busy_A,
   output logic                            busy_B,
   output logic                            ctrl_writeEnable,
   output logic [ADDR_WIDTH-1:0]           ctrl_writeReg,
   output logic [DATA_WIDTH-1:0]           data_writeReg,
   output gnt_id_t                         grant_id
);

   localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

   logic [NUM_REQ-1:0]    w_valid;
   logic [NUM_REQ-1:0]    w_starved;
   logic [NUM_REQ-1:0]    w_grant;
   logic [ADDR_WIDTH-1:0] w_reg  [NUM_REQ];
   logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

   logic                  w_any_starved;
   logic                  w_gnt_vld;
   gnt_id_t               w_gnt_id;
   logic [ADDR_WIDTH-1:0] w_sel_reg;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [NUM_REGS-1:0]   w_busy_nxt;

   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_wreg;
   logic [DATA_WIDTH-1:0] r_wdata;
   gnt_id_t               r_gid;
   logic [NUM_REGS-1:0]   r_busy;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
      wb_req_slot #(
         .DATA_WIDTH   (DATA_WIDTH),
         .ADDR_WIDTH   (ADDR_WIDTH),
         .STARVE_LIMIT (STARVE_LIMIT)
      ) u_slot (
         .clock        (clock),
         .ctrl_reset_n (ctrl_reset_n),
         .i_valid      (req_valid[g]),
         .o_ready      (req_ready[g]),
         .i_reg        (req_reg[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .i_data       (req_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .i_grant      (w_grant[g]),
         .o_valid      (w_valid[g]),
         .o_starved    (w_starved[g]),
         .o_reg        (w_reg[g]),
         .o_data       (w_data[g])
      );
   end

   assign w_any_starved = |w_starved;

   // Starved entries outrank everything; within a class the lowest index wins.
   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt_id   = GRANT_NONE;
      w_grant    = '0;
      w_sel_reg  = '0;
      w_sel_data = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_any_starved ? w_starved[i] : w_valid[i]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_id   = GNT_W'(i);
            w_grant    = '0;
            w_grant[i] = 1'b1;
            w_sel_reg  = w_reg[i];
            w_sel_data = w_data[i];
         end
      end
   end

   // Grant clears the destination first so a same-edge claim of it sticks.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_gnt_vld) begin
         w_busy_nxt[w_sel_reg] = 1'b0;
      end
      if (claim_valid && (claim_reg != '0)) begin
         w_busy_nxt[claim_reg] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         r_we    <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
         r_gid   <= GRANT_NONE;
         r_busy  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_gnt_vld) begin
            r_we    <= (w_sel_reg != '0);
            r_wreg  <= w_sel_reg;
            r_wdata <= w_sel_data;
            r_gid   <= w_gnt_id;
         end else begin
            r_we  <= 1'b0;
            r_gid <= GRANT_NONE;
         end
      end
   end

   assign busy_A           = r_busy[query_regA];
   assign busy_B           = r_busy[query_regB];
   assign ctrl_writeEnable = r_we;
   assign ctrl_writeReg    = r_wreg;
   assign data_writeReg    = r_wdata;
   assign grant_id         = r_gid;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-requester expectation queues are
// filled as writes are driven and drained by a monitor as grants appear.
module tb_regfile_wb_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_reg;
   logic [95:0] req_data;
   logic        claim_valid;
   logic [4:0]  claim_reg;
   logic [4:0]  query_regA;
   logic [4:0]  query_regB;
   logic        busy_A;
   logic        busy_B;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [1:0]  grant_id;

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   regfile_wb_arbiter dut (
      .clock            (clock),
      .ctrl_reset_n     (ctrl_reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_reg          (req_reg),
      .req_data         (req_data),
      .claim_valid      (claim_valid),
      .claim_reg        (claim_reg),
      .query_regA       (query_regA),
      .query_regB       (query_regB),
      .busy_A           (busy_A),
      .busy_B           (busy_B),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .grant_id         (grant_id)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int i, input logic [4:0] r, input logic [31:0] d, input bit track);
      exp_t e;
      e.r = r;
      e.d = d;
      req_valid[i]          = 1'b1;
      req_reg[5*i +: 5]     = r;
      req_data[32*i +: 32]  = d;
      if (track) begin
         case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 16 && (q0.size() + q1.size() + q2.size()) != 0; k++) tick();
      chk("drain_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      tick();
   endtask

   // Scoreboard: every write strobe must match the oldest pending write of its requester.
   always @(negedge clock) begin : monitor
      exp_t e;
      bit   have;
      if (ctrl_reset_n === 1'b1) begin
         if (grant_id == 2'd3) begin
            chk("idle_we", 32'(ctrl_writeEnable), 32'd0);
         end else begin
            have = 1'b0;
            case (grant_id)
               2'd0:    if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               2'd1:    if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            chk("grant_expected", 32'(have), 32'd1);
            if (have) begin
               chk("wr_reg", 32'(ctrl_writeReg), 32'(e.r));
               chk("wr_data", data_writeReg, e.d);
               chk("wr_en", 32'(ctrl_writeEnable), 32'(e.r != 5'd0));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  got;

      ctrl_reset_n = 1'b0;
      req_valid    = '0;
      req_reg      = '0;
      req_data     = '0;
      claim_valid  = 1'b0;
      claim_reg    = '0;
      query_regA   = 5'd9;
      query_regB   = 5'd0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", 32'(req_ready), 32'h7);
      chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
      chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
      chk("rst_data", data_writeReg, 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd3);
      chk("rst_busyA", 32'(busy_A), 32'd0);
      ctrl_reset_n = 1'b1;
      tick();

      // Single ALU write: ready low one cycle, strobe one cycle later.
      drive(0, 5'd5, 32'hDEADBEEF, 1'b1);
      tick();
      req_valid = '0;
      chk("t1_ready_held", 32'(req_ready), 32'h6);
      chk("t1_we_early", 32'(ctrl_writeEnable), 32'd0);
      tick();
      chk("t1_we", 32'(ctrl_writeEnable), 32'd1);
      chk("t1_gid", 32'(grant_id), 32'd0);
      chk("t1_reg", 32'(ctrl_writeReg), 32'd5);
      chk("t1_data", data_writeReg, 32'hDEADBEEF);
      chk("t1_ready_free", 32'(req_ready), 32'h7);
      tick();
      chk("t1_idle_gid", 32'(grant_id), 32'd3);

      // All three at once drain in priority order on consecutive cycles.
      drive(0, 5'd1, 32'hA1A1_0001, 1'b1);
      drive(1, 5'd2, 32'hA2A2_0002, 1'b1);
      drive(2, 5'd3, 32'hA3A3_0003, 1'b1);
      tick();
      req_valid = '0;
      chk("t2_ready_all_held", 32'(req_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t2_gid", 32'(grant_id), 32'(k));
         chk("t2_reg", 32'(ctrl_writeReg), 32'(k + 1));
         chk("t2_we", 32'(ctrl_writeEnable), 32'd1);
      end
      tick();
      chk("t2_idle_gid", 32'(grant_id), 32'd3);

      // ALU re-requests whenever free while the loader holds reg 7.
      drive(0, 5'd11, 32'hB000_0000, 1'b1);
      drive(2, 5'd7, 32'hC0DE_0007, 1'b1);
      tick();
      req_valid = '0;
      cnt = 0;
      got = 1'b0;
      for (int k = 0; k < 6; k++) begin
         req_valid[0] = 1'b0;
         if (req_ready[0] && k < 4) drive(0, 5'd11, 32'(32'hB000_0001 + k), 1'b1);
         tick();
         cnt++;
         if (!got && grant_id == 2'd2) begin
            got = 1'b1;
            chk("t3_loader_latency_le4", 32'(cnt <= 4), 32'd1);
         end
      end
      req_valid = '0;
      chk("t3_loader_granted", 32'(got), 32'd1);
      drain();

      // ALU and multdiv alternate; loader only wins by age promotion.
      drive(0, 5'd11, 32'hD000_0000, 1'b1);
      drive(1, 5'd12, 32'hE000_0000, 1'b1);
      drive(2, 5'd7, 32'hF00D_0007, 1'b1);
      tick();
      req_valid = '0;
      cnt = 0;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         req_valid = '0;
         if (k < 5) begin
            if (req_ready[0]) drive(0, 5'd11, 32'(32'hD000_0001 + k), 1'b1);
            if (req_ready[1]) drive(1, 5'd12, 32'(32'hE000_0001 + k), 1'b1);
         end
         tick();
         cnt++;
         if (!got && grant_id == 2'd2) begin
            got = 1'b1;
            chk("t3b_promote_cycle", 32'(cnt), 32'd5);
            chk("t3b_alu_blocked", 32'(req_ready[0]), 32'd0);
         end
      end
      req_valid = '0;
      chk("t3b_loader_granted", 32'(got), 32'd1);
      drain();

      // Scoreboard: claim, clear on grant, and same-edge claim beats clear.
      query_regA  = 5'd9;
      query_regB  = 5'd4;
      claim_valid = 1'b1;
      claim_reg   = 5'd9;
      tick();
      claim_valid = 1'b0;
      chk("t4_busyA_set", 32'(busy_A), 32'd1);
      chk("t4_busyB_other", 32'(busy_B), 32'd0);
      drive(1, 5'd9, 32'h0000_9999, 1'b1);
      tick();
      req_valid = '0;
      chk("t4_busy_before_grant", 32'(busy_A), 32'd1);
      tick();
      chk("t4_gid", 32'(grant_id), 32'd1);
      chk("t4_we", 32'(ctrl_writeEnable), 32'd1);
      chk("t4_busy_cleared", 32'(busy_A), 32'd0);
      tick();
      chk("t4_busy_stays_clear", 32'(busy_A), 32'd0);
      drive(1, 5'd9, 32'h0000_9A9A, 1'b1);
      tick();
      req_valid   = '0;
      claim_valid = 1'b1;
      claim_reg   = 5'd9;
      tick();
      claim_valid = 1'b0;
      chk("t4_same_edge_gid", 32'(grant_id), 32'd1);
      chk("t4_set_wins", 32'(busy_A), 32'd1);
      tick();
      chk("t4_set_wins_hold", 32'(busy_A), 32'd1);

      // Register 0: granted and drained, never strobed, never busy.
      claim_valid = 1'b1;
      claim_reg   = 5'd0;
      query_regB  = 5'd0;
      drive(2, 5'd0, 32'h0000_1234, 1'b1);
      tick();
      req_valid   = '0;
      claim_valid = 1'b0;
      chk("t5_ready_held", 32'(req_ready), 32'h3);
      chk("t5_busy0", 32'(busy_B), 32'd0);
      tick();
      chk("t5_gid", 32'(grant_id), 32'd2);
      chk("t5_we_zero", 32'(ctrl_writeEnable), 32'd0);
      chk("t5_data", data_writeReg, 32'h0000_1234);
      chk("t5_ready_free", 32'(req_ready), 32'h7);
      chk("t5_busy0_after", 32'(busy_B), 32'd0);
      tick();

      // Reset while two slots hold data: everything discarded.
      drive(0, 5'd20, 32'h2020_2020, 1'b0);
      drive(1, 5'd21, 32'h2121_2121, 1'b0);
      tick();
      req_valid = '0;
      chk("t6_ready_held", 32'(req_ready), 32'h4);
      ctrl_reset_n = 1'b0;
      #1;
      chk("t6_rst_we", 32'(ctrl_writeEnable), 32'd0);
      chk("t6_rst_gid", 32'(grant_id), 32'd3);
      chk("t6_rst_reg", 32'(ctrl_writeReg), 32'd0);
      chk("t6_rst_data", data_writeReg, 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'h7);
      chk("t6_rst_busy", 32'(busy_A), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      ctrl_reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t6_no_write", 32'(ctrl_writeEnable), 32'd0);
         chk("t6_no_grant", 32'(grant_id), 32'd3);
      end
      chk("t6_ready_free", 32'(req_ready), 32'h7);

      chk("final_queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
